// File: rtl/cb_adder_pkg.sv
// Shared defaults and configuration check for the pipelined carry-bypass adder.
package cb_adder_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_BLOCK  = 4;
  localparam int DEF_STAGES = 4;

  // Each stage must cover a whole number of bypass blocks.
  function automatic bit cfg_legal(input int width, input int block, input int stages);
    return (width > 0) && (block > 0) && (stages > 0) && ((width % (stages * block)) == 0);
  endfunction

endpackage

// File: rtl/cb_block.sv
// Combinational carry-bypass block: ripple inside, skip the chain when every bit propagates.
module cb_block
  import cb_adder_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign p    = a ^ b;
  assign c[0] = ci;

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK; gi++) begin : bit_slice
      assign s[gi]   = p[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (p[gi] & c[gi]);
    end
  endgenerate

  assign co = (&p) ? ci : c[BLOCK];

endmodule

// File: rtl/pipe_cb_adder.sv
// Pipelined carry-bypass adder/subtractor: one bit slice per stage, operands and
// finished sum bits ride along in skew registers, stall via a global advance enable.
module pipe_cb_adder
  import cb_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BLOCK  = DEF_BLOCK,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int SW = WIDTH / STAGES;
  localparam int NB = SW / BLOCK;

  generate
    if (!cfg_legal(WIDTH, BLOCK, STAGES)) begin : bad_cfg
      $error("pipe_cb_adder: WIDTH must be a multiple of STAGES*BLOCK");
    end
  endgenerate

  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  genvar gi, gj;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : stage
      localparam int LO  = gi * SW;
      localparam int REM = WIDTH - LO;

      logic [REM-1:0]   a_in;
      logic [REM-1:0]   b_in;
      logic             c_in;
      logic             v_in;
      logic [SW-1:0]    slice_s;
      logic [NB:0]      carry;
      logic [LO+SW-1:0] s_next;
      logic [LO+SW-1:0] s_reg;
      logic             c_reg;
      logic             v_reg;

      if (gi == 0) begin : head
        // Subtraction is A + ~B + 1; Cin is ignored in that mode.
        assign a_in   = A;
        assign b_in   = sub ? ~B : B;
        assign c_in   = sub | Cin;
        assign v_in   = in_valid;
        assign s_next = slice_s;
      end else begin : body
        assign a_in   = stage[gi-1].fwd.a_reg;
        assign b_in   = stage[gi-1].fwd.b_reg;
        assign c_in   = stage[gi-1].c_reg;
        assign v_in   = stage[gi-1].v_reg;
        assign s_next = {slice_s, stage[gi-1].s_reg};
      end

      assign carry[0] = c_in;

      for (gj = 0; gj < NB; gj++) begin : blk
        cb_block #(.BLOCK(BLOCK)) u_cb (
          .a  (a_in[gj*BLOCK +: BLOCK]),
          .b  (b_in[gj*BLOCK +: BLOCK]),
          .ci (carry[gj]),
          .s  (slice_s[gj*BLOCK +: BLOCK]),
          .co (carry[gj+1])
        );
      end

      // Data only loads with a real beat so the outputs hold across bubbles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg <= 1'b0;
          c_reg <= 1'b0;
          s_reg <= '0;
        end else if (adv) begin
          v_reg <= v_in;
          if (v_in) begin
            c_reg <= carry[NB];
            s_reg <= s_next;
          end
        end
      end

      if (gi < STAGES - 1) begin : fwd
        logic [REM-SW-1:0] a_reg;
        logic [REM-SW-1:0] b_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
          end else if (adv && v_in) begin
            a_reg <= a_in[REM-1:SW];
            b_reg <= b_in[REM-1:SW];
          end
        end
      end else begin : last
        logic ovf_reg;

        // Carry into the MSB is recovered from its sum bit and operand bits.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_reg <= 1'b0;
          end else if (adv && v_in) begin
            ovf_reg <= (slice_s[SW-1] ^ a_in[SW-1] ^ b_in[SW-1]) ^ carry[NB];
          end
        end
      end
    end
  endgenerate

  assign out_valid = stage[STAGES-1].v_reg;
  assign S         = stage[STAGES-1].s_reg;
  assign Cout      = stage[STAGES-1].c_reg;
  assign Ovf       = stage[STAGES-1].last.ovf_reg;

endmodule

// File: doc/pipe_cb_adder.md
PIPE_CB_ADDER -- requirements
Module: pipe_cb_adder

Interface
REQ-001 Parameter WIDTH, default 64: operand and sum width in bits.
REQ-002 Parameter BLOCK, default 4: carry-bypass block width in bits.
REQ-003 Parameter STAGES, default 4: pipeline stages; legal only if WIDTH % (STAGES*BLOCK) == 0.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 in_valid  input  1: operand beat present.
REQ-007 in_ready  output  1: block accepts the beat this cycle.
REQ-008 A  input  WIDTH: operand A.
REQ-009 B  input  WIDTH: operand B.
REQ-010 Cin  input  1: carry in; ignored when sub=1.
REQ-011 sub  input  1: 0 = A+B+Cin; 1 = A-B (A + ~B + 1).
REQ-012 out_valid  output  1: result beat present.
REQ-013 out_ready  input  1: downstream accepts the result.
REQ-014 S  output  WIDTH: sum or difference.
REQ-015 Cout  output  1: carry out of the MSB; for sub, 1 means no borrow.
REQ-016 Ovf  output  1: two's-complement signed overflow.

Function
REQ-017 Stage k (0..STAGES-1) shall add bit slice [(k+1)*W/STAGES-1 : k*W/STAGES] with the carry registered from stage k-1, built from carry-bypass blocks of BLOCK bits.
REQ-018 Each bypass block shall propagate its incoming carry directly when all BLOCK bit-propagate signals (a^b) are 1; otherwise it shall ripple.
REQ-019 Operand bits above the current stage and finished sum bits below it shall travel with the beat in skew registers, so that each beat is self-contained.
REQ-020 Latency shall be exactly STAGES cycles from the accept edge (in_valid & in_ready) to out_valid, with no backpressure.
REQ-021 Throughput shall be one beat per cycle while out_ready=1.
REQ-022 Pipeline advance: adv = ~out_valid | out_ready; every stage register shall load only when adv=1.
REQ-023 in_ready shall equal adv (combinational); a beat presented while in_ready=0 is not accepted and shall be held by the sender.
REQ-024 A stall (out_valid=1, out_ready=0) shall freeze every stage, with no loss, duplication or reordering.
REQ-025 Bubbles shall propagate as valid=0 stages, and S, Cout and Ovf shall hold their last values while out_valid=0.
REQ-026 Ovf shall equal carry-into-MSB XOR carry-out-of-MSB, using the effective B (~B when sub=1).
REQ-027 Arithmetic shall be modulo 2^WIDTH, with Cout reporting the bit lost.
REQ-028 When STAGES=1 the block shall degenerate to a single registered stage, with the same handshake and latency 1.

Reset
REQ-029 rst_n low shall clear, asynchronously, all stage valid bits, S=0, Cout=0 and Ovf=0; out_valid=0 immediately.
REQ-030 Reset asserted mid-operation shall discard all in-flight beats, and no stale result shall appear after release.
REQ-031 The first beat shall be accepted on the first rising edge with rst_n high.

Structure
REQ-032 The shared package cb_adder_pkg shall hold the default WIDTH, BLOCK and STAGES constants, plus the legality check expression.
REQ-033 The combinational sub-module cb_block shall have ports a[BLOCK], b[BLOCK], ci, s[BLOCK] and co; pipe_cb_adder shall instantiate it WIDTH/BLOCK times.
REQ-034 There shall be no other sub-modules, and no latches.

Verification (WIDTH=64, BLOCK=4, STAGES=4, out_ready=1 unless stated)
REQ-035 Beat A=0, B=1, Cin=1, sub=0 -> 4 cycles later out_valid=1, S=2, Cout=0, Ovf=0.
REQ-036 Back-to-back beats A=240, B=16 with Cin=0 then Cin=1 -> consecutive cycles S=256 then S=257, Cout=0.
REQ-037 A=all-ones, B=0, Cin=1 (full bypass chain) -> S=0, Cout=1; A=0x7FFF_FFFF_FFFF_FFFF, B=1, Cin=0 -> S=0x8000_0000_0000_0000, Ovf=1.
REQ-038 sub=1, A=5, B=7 -> S=0xFFFF_FFFF_FFFF_FFFE, Cout=0, Ovf=0; sub=1, A=7, B=5 -> S=2, Cout=1.
REQ-039 Stream 8 beats (A=i, B=i) with out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall, and outputs appear exactly as S=0, 2, 4, ..., 14 in order.
REQ-040 Accept 3 beats, then pulse rst_n low for 1 cycle -> out_valid=0 at once and no output thereafter; a new beat A=1, B=1 -> S=2 after 4 cycles.
